// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Word-organised byte-addressable data memory for the core's load/store path.
//   One request is accepted through a valid/ready channel. The block answers with a
//   one-cycle response pulse two cycles later, or three cycles later for a split access.
//   Range and alignment are checked when the request is accepted.
//
// Configuration macro
//   DM_MISALIGN_SPLIT_EN : when defined, an access that crosses a word boundary runs as
//                          two word accesses through SPLIT.
//                          When undefined, every misaligned access is rejected.
//
// Ports
//   clk_i        clock; all state changes happen on the rising edge
//   rst_i        synchronous active-high reset; memory contents are kept
//   req_valid_i  a request is present
//   req_ready_o  the block can accept a request (IDLE and not in reset)
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address
//   req_ctrl_i   000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
//   req_wdata_i  store data, LSB-aligned
//   resp_valid_o one-cycle response pulse
//   resp_err_o   the request was rejected (qualified by resp_valid_o)
//   rd_data_o    load result, sign- or zero-extended; 0 for stores and errors
//
// States
//   S_IDLE   | waiting for a request
//   S_ACCESS | access the first (or only) word
//   S_SPLIT  | access the following word of a boundary-crossing access
//   S_RESP   | drive the response pulse

module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 32,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [2:0]        req_ctrl_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic              resp_err_o,
    output logic [31:0]       rd_data_o
);

    localparam int              IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
`ifdef DM_MISALIGN_SPLIT_EN
        , S_SPLIT = 2'd3
`endif
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic [31:0]        rd_q, rd_d;
    logic [31:0]        mem_q [DEPTH_WORDS];

    // Load result: select bytes starting at the offset, then extend by ctrl.
    function automatic logic [31:0] load_ext(input logic [63:0] raw,
                                             input logic [1:0]  off,
                                             input logic [2:0]  ctrl);
        logic [31:0] s;
        s = 32'(raw >> {off, 3'b000});
        case (ctrl)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'b0, s[7:0]};
            3'b101:  return {16'b0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Checks made at accept time.
    logic [ADDR_W:0] widx_a;
    logic [1:0]      off_a;
    logic            bad_ctrl_a, bad_store_a, misal_a, range_bad_a, err_a;

    assign widx_a      = {3'b000, req_addr_i[ADDR_W-1:2]};
    assign off_a       = req_addr_i[1:0];
    assign bad_ctrl_a  = (req_ctrl_i == 3'b011) || (req_ctrl_i[2] && req_ctrl_i[1]);
    assign bad_store_a = req_we_i && req_ctrl_i[2];

`ifdef DM_MISALIGN_SPLIT_EN
    logic cross_a, cross_q, cross_d;
    logic [31:0] lo_q, lo_d;
    assign cross_a     = ((req_ctrl_i[1:0] == 2'b01) && (off_a == 2'd3)) ||
                         ((req_ctrl_i[1:0] == 2'b10) && (off_a != 2'd0));
    assign misal_a     = 1'b0;
    // Both words of a split are range-checked so a rejected split writes nothing.
    assign range_bad_a = (widx_a >= DEPTH_L) || (cross_a && ((widx_a + 1'b1) >= DEPTH_L));
`else
    assign misal_a     = ((req_ctrl_i[1:0] == 2'b01) && off_a[0]) ||
                         ((req_ctrl_i[1:0] == 2'b10) && (off_a != 2'd0));
    assign range_bad_a = (widx_a >= DEPTH_L);
`endif
    assign err_a = bad_ctrl_a || bad_store_a || misal_a || range_bad_a;

    // Store byte lanes and data for the first and (optionally) second word.
    logic [3:0]  size_mask;
    logic [3:0]  be0;
    logic [31:0] wr_data0;
    logic        we0;
    logic [31:0] rd_word0;

    assign size_mask = (ctrl_q[1:0] == 2'b00) ? 4'b0001 :
                       (ctrl_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign we0       = (state_q == S_ACCESS) && we_q && !err_q;
    assign rd_word0  = mem_q[idx_q];

`ifdef DM_MISALIGN_SPLIT_EN
    logic [63:0] wide;
    logic [7:0]  be8;
    logic [3:0]  be1;
    logic [31:0] wr_data1;
    logic        we1;
    logic [IDX_W-1:0] idx1;
    logic [31:0] rd_word1;

    assign wide     = {32'b0, wdata_q} << {off_q, 3'b000};
    assign be8      = {4'b0000, size_mask} << off_q;
    assign wr_data0 = wide[31:0];
    assign be0      = be8[3:0];
    assign wr_data1 = wide[63:32];
    assign be1      = be8[7:4];
    assign we1      = (state_q == S_SPLIT) && we_q;
    assign idx1     = idx_q + 1'b1;
    assign rd_word1 = mem_q[idx1];
`else
    assign wr_data0 = wdata_q << {off_q, 3'b000};
    assign be0      = size_mask << off_q;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        ctrl_d  = ctrl_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rd_d    = rd_q;
`ifdef DM_MISALIGN_SPLIT_EN
        cross_d = cross_q;
        lo_d    = lo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    ctrl_d  = req_ctrl_i;
                    off_d   = off_a;
                    wdata_d = req_wdata_i;
                    idx_d   = widx_a[IDX_W-1:0];
                    err_d   = err_a;
`ifdef DM_MISALIGN_SPLIT_EN
                    cross_d = cross_a;
`endif
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (err_q || we_q) rd_d = 32'b0;
                else               rd_d = load_ext({32'b0, rd_word0}, off_q, ctrl_q);
                state_d = S_RESP;
`ifdef DM_MISALIGN_SPLIT_EN
                lo_d = rd_word0;
                if (!err_q && cross_q) state_d = S_SPLIT;
`endif
            end
`ifdef DM_MISALIGN_SPLIT_EN
            S_SPLIT: begin
                if (we_q) rd_d = 32'b0;
                else      rd_d = load_ext({rd_word1, lo_q}, off_q, ctrl_q);
                state_d = S_RESP;
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            ctrl_q  <= 3'b0;
            off_q   <= 2'b0;
            wdata_q <= 32'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= 32'b0;
`ifdef DM_MISALIGN_SPLIT_EN
            cross_q <= 1'b0;
            lo_q    <= 32'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            ctrl_q  <= ctrl_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
`ifdef DM_MISALIGN_SPLIT_EN
            cross_q <= cross_d;
            lo_q    <= lo_d;
`endif
        end
    end

    // Writes are suppressed on a reset edge, so a reset during SPLIT keeps only
    // the bytes already committed in ACCESS.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we0 && be0[b]) mem_q[idx_q][8*b +: 8] <= wr_data0[8*b +: 8];
`ifdef DM_MISALIGN_SPLIT_EN
                if (we1 && be1[b]) mem_q[idx1][8*b +: 8] <= wr_data1[8*b +: 8];
`endif
            end
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_err_o   = resp_valid_o && err_q;
    assign rd_data_o    = resp_valid_o ? rd_q : 32'b0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam int DEPTH_WORDS = 32;
    localparam int ADDR_W      = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_ctrl;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       rd_data;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_ctrl_i  (req_ctrl),
        .req_wdata_i (req_wdata),
        .resp_valid_o(resp_valid),
        .resp_err_o  (resp_err),
        .rd_data_o   (rd_data)
    );

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] C_B = 3'b000, C_H = 3'b001, C_W = 3'b010,
                           C_BU = 3'b100, C_HU = 3'b101, C_BAD = 3'b011;

`ifdef DM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_ON = 1'b1;
`else
    localparam bit SPLIT_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the expected response, drive one request, then pop and compare the response.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] ctrl, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_data, input int exp_lat);
        exp_t e;
        int   lat;
        bit   got;
        sb_q.push_back('{tag, exp_err, exp_data, exp_lat});
        @(negedge clk);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_ctrl  = ctrl;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hffff_fffc;
        req_ctrl  = 3'b111;
        req_wdata = 32'h5a5a_5a5a;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 6) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
        end
        check({tag, "_resp_seen"}, {31'b0, got}, 32'd1);
        e = sb_q.pop_front();
        if (got) begin
            check({e.tag, "_err"},  {31'b0, resp_err}, {31'b0, e.err});
            check({e.tag, "_data"}, rd_data, e.data);
            check({e.tag, "_lat"},  lat, e.lat);
            check({e.tag, "_busy"}, {31'b0, req_ready}, 32'd0);
            @(negedge clk);
            check({e.tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
        end
    endtask

    initial begin
        int sl;
        sl = SPLIT_ON ? 3 : 2;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_ctrl  = 3'b0;
        req_wdata = '0;

        // 1: reset state, then a word store/load round trip
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_err",   {31'b0, resp_err}, 32'd0);
        check("rst_data",  rd_data, 32'd0);
        rst = 1'b0;
        do_req("sw04", 1, 32'h04, C_W, 32'h8bad_f00d, 0, 32'h0, 2);
        do_req("lw04", 0, 32'h04, C_W, 32'h0,         0, 32'h8bad_f00d, 2);

        // 2: byte merge and byte sign/zero extension
        do_req("sw08",  1, 32'h08, C_W, 32'hffff_ffff, 0, 32'h0, 2);
        do_req("sb09",  1, 32'h09, C_B, 32'h0000_0012, 0, 32'h0, 2);
        do_req("lw08",  0, 32'h08, C_W, 32'h0,         0, 32'hffff_12ff, 2);
        do_req("sb09b", 1, 32'h09, C_B, 32'hffff_ff80, 0, 32'h0, 2);
        do_req("lb09",  0, 32'h09, C_B, 32'h0,         0, 32'hffff_ff80, 2);
        do_req("lbu09", 0, 32'h09, C_BU, 32'h0,        0, 32'h0000_0080, 2);

        // 3: halfwords and illegal ctrl codes
        do_req("sw10z", 1, 32'h10, C_W, 32'h0,         0, 32'h0, 2);
        do_req("sh10",  1, 32'h10, C_H, 32'h1234_8001, 0, 32'h0, 2);
        do_req("lh10",  0, 32'h10, C_H, 32'h0,         0, 32'hffff_8001, 2);
        do_req("lhu10", 0, 32'h10, C_HU, 32'h0,        0, 32'h0000_8001, 2);
        do_req("st011", 1, 32'h10, C_BAD, 32'hdead_beef, 1, 32'h0, 2);
        do_req("ld011", 0, 32'h10, C_BAD, 32'h0,       1, 32'h0, 2);
        do_req("sbu",   1, 32'h10, C_BU, 32'hdead_beef, 1, 32'h0, 2);
        do_req("ld111", 0, 32'h10, 3'b111, 32'h0,      1, 32'h0, 2);
        do_req("lw10",  0, 32'h10, C_W, 32'h0,         0, 32'h0000_8001, 2);

        // 4: range boundary
        do_req("sw7c",  1, 32'h7c, C_W, 32'h1122_3344, 0, 32'h0, 2);
        do_req("lw80",  0, 32'h80, C_W, 32'h0,         1, 32'h0, 2);
        do_req("sw80",  1, 32'h80, C_W, 32'hcafe_babe, 1, 32'h0, 2);
        do_req("sw7e",  1, 32'h7e, C_W, 32'hcafe_babe, 1, 32'h0, 2);
        do_req("lb7f",  0, 32'h7f, C_B, 32'h0,         0, 32'h0000_0011, 2);
        do_req("lw7c",  0, 32'h7c, C_W, 32'h0,         0, 32'h1122_3344, 2);
        do_req("sw00",  1, 32'h00, C_W, 32'h0,         0, 32'h0, 2);
        do_req("lw00r", 0, 32'h00, C_W, 32'h0,         0, 32'h0, 2);

        // 5: word-crossing accesses
        do_req("sw0cz", 1, 32'h0c, C_W, 32'h0, 0, 32'h0, 2);
        do_req("sw10z2", 1, 32'h10, C_W, 32'h0, 0, 32'h0, 2);
        do_req("sw0d",  1, 32'h0d, C_W, 32'haabb_ccdd, !SPLIT_ON, 32'h0, sl);
        do_req("lw0c",  0, 32'h0c, C_W, 32'h0, 0, SPLIT_ON ? 32'hbbcc_dd00 : 32'h0, 2);
        do_req("lw10s", 0, 32'h10, C_W, 32'h0, 0, SPLIT_ON ? 32'h0000_00aa : 32'h0, 2);
        if (SPLIT_ON) begin
            do_req("lw0d", 0, 32'h0d, C_W, 32'h0, 0, 32'haabb_ccdd, 3);
            do_req("lh0f", 0, 32'h0f, C_H, 32'h0, 0, 32'hffff_aabb, 3);
            do_req("lh0d", 0, 32'h0d, C_H, 32'h0, 0, 32'hffff_ccdd, 2);
        end else begin
            do_req("lw0d", 0, 32'h0d, C_W, 32'h0, 1, 32'h0, 2);
            do_req("lh0f", 0, 32'h0f, C_H, 32'h0, 1, 32'h0, 2);
            do_req("lh0d", 0, 32'h0d, C_H, 32'h0, 1, 32'h0, 2);
        end

        // 6: reset during SPLIT of a crossing store
        do_req("sw0cz3", 1, 32'h0c, C_W, 32'h0,         0, 32'h0, 2);
        do_req("sw10p",  1, 32'h10, C_W, 32'h5566_7788, 0, 32'h0, 2);
        if (SPLIT_ON) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h0e;
            req_ctrl  = C_W;
            req_wdata = 32'h4433_2211;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("mid_access_valid", {31'b0, resp_valid}, 32'd0);
            @(negedge clk);
            check("mid_split_valid", {31'b0, resp_valid}, 32'd0);
            rst = 1'b1;
            @(negedge clk);
            check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
            check("mid_rst_ready", {31'b0, req_ready}, 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check("post_rst_valid", {31'b0, resp_valid}, 32'd0);
            do_req("lw0c_rst", 0, 32'h0c, C_W, 32'h0, 0, 32'h2211_0000, 2);
            do_req("lw10_rst", 0, 32'h10, C_W, 32'h0, 0, 32'h5566_7788, 2);
        end else begin
            do_req("sw0e", 1, 32'h0e, C_W, 32'h4433_2211, 1, 32'h0, 2);
            do_req("lw0c_rst", 0, 32'h0c, C_W, 32'h0, 0, 32'h0, 2);
            do_req("lw10_rst", 0, 32'h10, C_W, 32'h0, 0, 32'h5566_7788, 2);
        end

        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
